// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - request/response handshake bundle for the multiply sequencer
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_err;

  // requester side: issues operands, consumes results
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_hi, res_lo, res_err
  );

  // sequencer side
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_hi, res_lo, res_err
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequencer between the datapath and the Booth multiplier
module mul_seq_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TIMEOUT     = 12,
  parameter int ZERO_BYPASS = 1
) (
  input  logic               clk,
  input  logic               reset,
  mul_seq_ctrl_if.slave      bus,
  output logic [WIDTH-1:0]   m_mc,
  output logic [WIDTH-1:0]   m_mp,
  output logic               m_start,
  input  logic [2*WIDTH-1:0] m_prod,
  input  logic               m_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  wait_cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic           err;
  logic           accept;
  logic           zero_op;
  logic           capture;
  logic           timed_out;

  // state register; reset abandons any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // next-state decode and handshake outputs
  always_comb begin
    accept    = (state == IDLE) && bus.req_valid;
    zero_op   = (ZERO_BYPASS != 0) && ((bus.req_a == '0) || (bus.req_b == '0));
    // busy is meaningless until the multiplier has seen start, so skip wait_cnt==0
    capture   = (state == WAIT) && (wait_cnt != '0) && !m_busy;
    timed_out = (state == WAIT) && (wait_cnt == CW'(TIMEOUT));
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = zero_op ? DONE : START;
      START:   next_state = WAIT;
      WAIT:    if (capture || timed_out) next_state = DONE;
      DONE:    if (bus.res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign m_start       = (state == START);
  assign bus.res_hi    = hi;
  assign bus.res_lo    = lo;
  assign bus.res_err   = err;

  // operand latch, wait counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      hi       <= '0;
      lo       <= '0;
      err      <= 1'b0;
      m_mc     <= '0;
      m_mp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m_mc <= bus.req_a;
            m_mp <= bus.req_b;
            if (zero_op) begin
              hi  <= '0;
              lo  <= '0;
              err <= 1'b0;
            end
          end
        end
        START: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          // the multiplier keeps shifting afterwards, so prod is only valid this cycle
          if (capture) begin
            {hi, lo} <= m_prod;
            err      <= 1'b0;
          end else if (timed_out) begin
            hi  <= '0;
            lo  <= '0;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - scoreboard bench for mul_seq_ctrl
module tb_mul_seq_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_seq_ctrl_if #(.WIDTH(W)) bus ();

  logic [W-1:0]   m_mc;
  logic [W-1:0]   m_mp;
  logic           m_start;
  logic [2*W-1:0] m_prod = 16'h1234;
  logic           m_busy = 1'b0;
  logic [3:0]     mcnt = 4'd0;
  bit             stuck = 1'b0;
  bit             hold = 1'b0;
  int             cyc = 0;
  int             total = 0;
  int             bad = 0;

  mul_seq_ctrl #(.WIDTH(W), .TIMEOUT(12), .ZERO_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .m_mc(m_mc), .m_mp(m_mp), .m_start(m_start), .m_prod(m_prod), .m_busy(m_busy)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic        err;
    int          lat;
    int          starts;
    int          acc_cyc;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // multiplier stand-in: 8 shift steps after start, then keeps scrambling prod
  always @(posedge clk) begin
    if (m_start) begin
      mcnt   <= 4'd0;
      m_busy <= 1'b1;
      m_prod <= m_prod ^ 16'hA5C3;
    end else if (m_busy) begin
      if (!stuck && mcnt == 4'd7) begin
        m_busy <= 1'b0;
        m_prod <= {{8{m_mc[7]}}, m_mc} * {{8{m_mp[7]}}, m_mp};
      end else begin
        m_prod <= {m_prod[14:0], m_prod[15]} ^ 16'h1357;
      end
      if (!stuck) mcnt <= mcnt + 4'd1;
    end else begin
      m_prod <= {m_prod[0], m_prod[15:1]} ^ 16'h5A5A;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // consumer backpressure
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.res_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: compares every presented result against the queue head
  initial begin
    bit prev_valid;
    int start_seen;
    prev_valid = 1'b0;
    start_seen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        start_seen = 0;
      end else begin
        if (m_start) start_seen++;
        if (bus.res_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'(bus.res_valid), 32'd0);
          end else begin
            if (!prev_valid) begin
              chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
              chk("start_pulses", 32'(start_seen), 32'(q[0].starts));
              chk("m_mc", 32'(m_mc), 32'(q[0].a));
              chk("m_mp", 32'(m_mp), 32'(q[0].b));
            end
            chk("res_hi", 32'(bus.res_hi), 32'(q[0].prod[15:8]));
            chk("res_lo", 32'(bus.res_lo), 32'(q[0].prod[7:0]));
            chk("res_err", 32'(bus.res_err), 32'(q[0].err));
            chk("req_ready_in_done", 32'(bus.req_ready), 32'd0);
            if (bus.res_ready) begin
              void'(q.pop_front());
              start_seen = 0;
            end
          end
        end
        prev_valid = bus.res_valid && !bus.res_ready;
      end
    end
  end

  task automatic do_req(input logic [7:0] a, input logic [7:0] b, input bit push, input bit err_exp);
    exp_t e;
    int n;
    int p;
    n = 0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    p = int'($signed(a)) * int'($signed(b));
    e.a = a;
    e.b = b;
    e.acc_cyc = cyc;
    if (err_exp) begin
      e.prod = 16'h0; e.err = 1'b1; e.lat = 14; e.starts = 1;
    end else if (a == 8'h00 || b == 8'h00) begin
      e.prod = 16'h0; e.err = 1'b0; e.lat = 0; e.starts = 0;
    end else begin
      e.prod = p[15:0]; e.err = 1'b0; e.lat = 10; e.starts = 1;
    end
    if (push) q.push_back(e);
    bus.req_valid = 1'b0;
    bus.req_a = 8'($urandom);
    bus.req_b = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    int n;
    bus.req_valid = 1'b0;
    bus.req_a = 8'h00;
    bus.req_b = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_hi", 32'(bus.res_hi), 32'd0);
    chk("rst_res_lo", 32'(bus.res_lo), 32'd0);
    chk("rst_res_err", 32'(bus.res_err), 32'd0);
    chk("rst_m_start", 32'(m_start), 32'd0);
    chk("rst_m_mc", 32'(m_mc), 32'd0);
    chk("rst_m_mp", 32'(m_mp), 32'd0);

    // 3*5 with the consumer stalled for 5 cycles
    hold = 1'b1;
    do_req(8'h03, 8'h05, 1'b1, 1'b0);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid", 32'(bus.res_valid), 32'd1);
    repeat (5) @(negedge clk);
    chk("hold_still_valid", 32'(bus.res_valid), 32'd1);
    hold = 1'b0;
    drain();

    do_req(8'hFD, 8'h05, 1'b1, 1'b0);
    do_req(8'h80, 8'h80, 1'b1, 1'b0);
    do_req(8'h7F, 8'h81, 1'b1, 1'b0);
    do_req(8'h00, 8'h7F, 1'b1, 1'b0);
    do_req(8'h3C, 8'h00, 1'b1, 1'b0);
    drain();

    // reset while waiting (wait_cnt==4)
    do_req(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
    chk("abort_m_start", 32'(m_start), 32'd0);
    do_req(8'h06, 8'h07, 1'b1, 1'b0);
    drain();

    // hung multiplier
    stuck = 1'b1;
    do_req(8'h09, 8'h09, 1'b1, 1'b1);
    drain();
    stuck = 1'b0;

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) a = 8'h00;
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      do_req(a, b, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end
endmodule
